ssc_input_loader: RTL and testbench

SSC_INPUT_LOADER -- requirements
Module: ssc_input_loader

---
 rtl/ssc_input_loader_if.sv | 28 ++
 rtl/ssc_input_loader.sv | 146 ++++++++++++++
 tb/tb_ssc_input_loader.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssc_input_loader_if.sv
// Beat-stream input and frame-handoff bundle for ssc_input_loader.
// slave = the loader; master = beat source plus downstream calculator.
interface ssc_input_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_card;
    logic [3:0]  in_snack;
    logic [3:0]  in_price;
    logic [8:0]  in_money;
    logic [63:0] card_num;
    logic [31:0] snack_num;
    logic [31:0] price;
    logic [8:0]  input_money;
    logic        out_valid;
    logic        out_ready;
    logic        abort;
    logic        fmt_err;

    modport slave (
        input  in_valid, in_card, in_snack, in_price, in_money, out_ready,
        output in_ready, card_num, snack_num, price, input_money, out_valid, abort, fmt_err
    );

    modport master (
        output in_valid, in_card, in_snack, in_price, in_money, out_ready,
        input  in_ready, card_num, snack_num, price, input_money, out_valid, abort, fmt_err
    );
endinterface

// File: rtl/ssc_input_loader.sv
// Assembles a 16-beat frame (card digits, 8 items, money) and holds it until consumed.
// Optional card-digit range check enabled by defining SSC_LOAD_DIGIT_CHECK_EN.
module ssc_input_loader (
    input  logic              clk,
    input  logic              rst,
    ssc_input_loader_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_in_ready;
    logic        r_out_valid;
    logic        r_abort;
    logic [63:0] r_card_num;
    logic [31:0] r_snack_num;
    logic [31:0] r_price;
    logic [8:0]  r_input_money;

    logic        w_accept;
    logic [3:0]  w_beat_idx;
    logic        w_last_beat;
    logic [63:0] w_card_next;
    logic [31:0] w_snack_next;
    logic [31:0] w_price_next;

    assign w_accept    = bus.in_valid & r_in_ready;
    assign w_beat_idx  = (r_state == LOAD) ? r_cnt : 4'd0;
    assign w_last_beat = (r_state == LOAD) && (r_cnt == 4'd15);

    // Beat k overwrites only its own nibble; beat 0 lands in the top nibble.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_card
            assign w_card_next[63-4*gi -: 4] = (w_beat_idx == 4'(gi)) ? bus.in_card
                                                                       : r_card_num[63-4*gi -: 4];
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_item
            assign w_snack_next[31-4*gi -: 4] = (w_beat_idx == 4'(gi)) ? bus.in_snack
                                                                        : r_snack_num[31-4*gi -: 4];
            assign w_price_next[31-4*gi -: 4] = (w_beat_idx == 4'(gi)) ? bus.in_price
                                                                        : r_price[31-4*gi -: 4];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= 4'd0;
            r_in_ready    <= 1'b1;
            r_out_valid   <= 1'b0;
            r_abort       <= 1'b0;
            r_card_num    <= 64'd0;
            r_snack_num   <= 32'd0;
            r_price       <= 32'd0;
            r_input_money <= 9'd0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_card_num    <= w_card_next;
                        r_snack_num   <= w_snack_next;
                        r_price       <= w_price_next;
                        r_input_money <= bus.in_money;
                        r_cnt         <= 4'd1;
                        r_state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        r_card_num  <= w_card_next;
                        r_snack_num <= w_snack_next;
                        r_price     <= w_price_next;
                        if (w_last_beat) begin
                            r_state     <= FULL;
                            r_cnt       <= 4'd0;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end else begin
                        // A gap inside a frame truncates it; the partial data is simply abandoned.
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                        r_abort <= 1'b1;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= 4'd0;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef SSC_LOAD_DIGIT_CHECK_EN
    logic r_digit_bad;
    logic r_fmt_err;
    logic w_digit_bad;

    assign w_digit_bad = (bus.in_card > 4'd9);

    // The running flag restarts on beat 0; the visible error is captured only as the frame completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit_bad <= 1'b0;
            r_fmt_err   <= 1'b0;
        end else if (w_accept && (r_state == IDLE)) begin
            r_digit_bad <= w_digit_bad;
        end else if (w_accept) begin
            r_digit_bad <= r_digit_bad | w_digit_bad;
            if (w_last_beat) begin
                r_fmt_err <= r_digit_bad | w_digit_bad;
            end
        end else if ((r_state == FULL) && bus.out_ready) begin
            r_fmt_err <= 1'b0;
        end
    end

    assign bus.fmt_err = r_fmt_err;
`else
    assign bus.fmt_err = 1'b0;
`endif

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.abort       = r_abort;
    assign bus.card_num    = r_card_num;
    assign bus.snack_num   = r_snack_num;
    assign bus.price       = r_price;
    assign bus.input_money = r_input_money;
endmodule

// File: tb/tb_ssc_input_loader.sv
// Randomized scoreboard bench for ssc_input_loader: driver pushes expected frames, monitor pops on out_valid.
module tb_ssc_input_loader;
    logic clk;
    logic rst;

    ssc_input_loader_if bus();

    ssc_input_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0][3:0] card;
        logic [7:0][3:0]  snack;
        logic [7:0][3:0]  price;
        logic [8:0]       money;
    } frame_t;

    typedef struct packed {
        logic [63:0] card;
        logic [31:0] snack;
        logic [31:0] price;
        logic [8:0]  money;
        logic        fmt;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail = 0;
    int exp_aborts = 0;
    int seen_aborts = 0;
    int frames_pushed = 0;
    int frames_seen = 0;

    logic [63:0] snap_card;
    logic [31:0] snap_snack;
    logic [31:0] snap_price;
    logic [8:0]  snap_money;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: outputs are the beat values concatenated in arrival order.
    function automatic exp_t model(input frame_t f);
        exp_t e;
        e.card  = 64'd0;
        e.snack = 32'd0;
        e.price = 32'd0;
        for (int k = 0; k < 16; k++) e.card = {e.card[59:0], f.card[k]};
        for (int k = 0; k < 8; k++) begin
            e.snack = {e.snack[27:0], f.snack[k]};
            e.price = {e.price[27:0], f.price[k]};
        end
        e.money = f.money;
        e.fmt   = 1'b0;
`ifdef SSC_LOAD_DIGIT_CHECK_EN
        for (int k = 0; k < 16; k++) if (f.card[k] > 4'd9) e.fmt = 1'b1;
`endif
        return e;
    endfunction

    function automatic frame_t rand_frame(input bit allow_bad);
        frame_t f;
        for (int k = 0; k < 16; k++)
            f.card[k] = (allow_bad && $urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                                  : 4'($urandom_range(0, 9));
        for (int k = 0; k < 8; k++) begin
            f.snack[k] = 4'($urandom);
            f.price[k] = 4'($urandom);
        end
        f.money = 9'($urandom_range(0, 511));
        return f;
    endfunction

    task automatic drive_noise();
        bus.in_card  = 4'($urandom);
        bus.in_snack = 4'($urandom);
        bus.in_price = 4'($urandom);
        bus.in_money = 9'($urandom);
    endtask

    task automatic drive_beat(input frame_t f, input int b);
        drive_noise();
        bus.in_valid = 1'b1;
        bus.in_card  = f.card[b];
        if (b < 8) begin
            bus.in_snack = f.snack[b];
            bus.in_price = f.price[b];
        end
        if (b == 0) bus.in_money = f.money;
    endtask

    // Called at posedge+1; returns at posedge+1 with reset released and loader idle.
    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #2;
        check("rst_card", bus.card_num, 64'd0);
        check("rst_snack", bus.snack_num, 64'd0);
        check("rst_price", bus.price, 64'd0);
        check("rst_money", bus.input_money, 64'd0);
        check("rst_out_valid", bus.out_valid, 64'd0);
        check("rst_abort", bus.abort, 64'd0);
        check("rst_fmt_err", bus.fmt_err, 64'd0);
        check("rst_in_ready", bus.in_ready, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // cut_at: -1 none, 1..15 cut before that beat, 16 reset while FULL (cut_rst must be 1).
    task automatic run_frame(input frame_t f, input int cut_at, input bit cut_rst,
                             input int stall, input bit noise);
        if (cut_at < 0 || cut_at == 16) begin
            sb.push_back(model(f));
            frames_pushed++;
        end
        for (int b = 0; b < 16; b++) begin
            if (b == cut_at) begin
                if (cut_rst) begin
                    do_reset();
                end else begin
                    bus.in_valid = 1'b0;
                    drive_noise();
                    exp_aborts++;
                    @(posedge clk);
                    #1;
                    check("abort_pulse", bus.abort, 64'd1);
                end
                return;
            end
            drive_beat(f, b);
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("frame_latency", bus.out_valid, (b == 15) ? 64'd1 : 64'd0);
        end
        snap_card  = bus.card_num;
        snap_snack = bus.snack_num;
        snap_price = bus.price;
        snap_money = bus.input_money;
        if (cut_at == 16) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b0;
            @(posedge clk);
            #1;
            do_reset();
            return;
        end
        for (int s = 0; s < stall; s++) begin
            bus.out_ready = 1'b0;
            drive_noise();
            bus.in_valid = noise;
            @(posedge clk);
            #1;
            check("stall_hold", bus.out_valid, 64'd1);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = noise;
        @(posedge clk);
        #1;
        check("handoff_release", bus.out_valid, 64'd0);
        check("handoff_ready", bus.in_ready, 64'd1);
        bus.in_valid = 1'b0;
    endtask

    // Monitor: compares every held-frame cycle against the scoreboard head.
    initial begin
        bit   prev_valid;
        bit   prev_abort;
        exp_t cur;
        prev_valid = 1'b0;
        prev_abort = 1'b0;
        cur = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_valid = 1'b0;
                prev_abort = 1'b0;
                continue;
            end
            check("in_ready_vs_state", bus.in_ready, {63'd0, ~bus.out_valid});
            if (bus.out_valid) begin
                if (!prev_valid) begin
                    check("sb_nonempty", (sb.size() != 0), 64'd1);
                    if (sb.size() != 0) cur = sb.pop_front();
                    frames_seen++;
                    $display("[TB] frame %0d card=%h snack=%h price=%h money=%0d fmt_err=%0b",
                             frames_seen, bus.card_num, bus.snack_num, bus.price,
                             bus.input_money, bus.fmt_err);
                end
                check("card_num", bus.card_num, cur.card);
                check("snack_num", bus.snack_num, {32'd0, cur.snack});
                check("price", bus.price, {32'd0, cur.price});
                check("input_money", bus.input_money, {55'd0, cur.money});
                check("fmt_err", bus.fmt_err, {63'd0, cur.fmt});
            end else begin
                check("fmt_err_idle", bus.fmt_err, 64'd0);
            end
            if (bus.abort) begin
                seen_aborts++;
                $display("[TB] abort %0d observed", seen_aborts);
                if (prev_abort) check("abort_width", 64'd2, 64'd1);
            end
            prev_valid = bus.out_valid;
            prev_abort = bus.abort;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f;
        int     digits [16] = '{4, 5, 3, 9, 1, 2, 7, 8, 0, 3, 5, 6, 2, 8, 1, 6};
        int     r;
        int     cut;
        bit     by_rst;

        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_card   = 4'd0;
        bus.in_snack  = 4'd0;
        bus.in_price  = 4'd0;
        bus.in_money  = 9'd0;
        #2;
        do_reset();

        // Directed frame with known packing.
        for (int k = 0; k < 16; k++) f.card[k] = 4'(digits[k]);
        for (int k = 0; k < 8; k++) begin
            f.snack[k] = 4'(k + 1);
            f.price[k] = 4'(k);
        end
        f.money = 9'd200;
        run_frame(f, -1, 1'b0, 0, 1'b0);
        check("directed_snack", snap_snack, 64'h12345678);
        check("directed_price", snap_price, 64'h01234567);
        check("directed_money", snap_money, 64'd200);
        check("directed_card", snap_card, 64'h4539127803562816);

        // Held frame under back-pressure with in_valid still high.
        run_frame(rand_frame(1'b0), -1, 1'b0, 5, 1'b1);

        // Truncation after beat 7, then a normal frame.
        run_frame(rand_frame(1'b0), 8, 1'b0, 0, 1'b0);
        run_frame(rand_frame(1'b0), -1, 1'b0, 0, 1'b0);

        // Reset at beat 10, then a fresh frame.
        run_frame(rand_frame(1'b0), 10, 1'b1, 0, 1'b0);
        run_frame(rand_frame(1'b0), -1, 1'b0, 1, 1'b0);

        // Non-decimal digit at beat 3, then a clean frame.
        f = rand_frame(1'b0);
        f.card[3] = 4'hA;
        run_frame(f, -1, 1'b0, 2, 1'b0);
        run_frame(rand_frame(1'b0), -1, 1'b0, 0, 1'b0);

        // Reset while a frame is held, then a fresh frame with maximum money.
        run_frame(rand_frame(1'b0), 16, 1'b1, 0, 1'b0);
        f = rand_frame(1'b1);
        f.money = 9'd511;
        run_frame(f, -1, 1'b0, 0, 1'b1);

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            cut = -1;
            by_rst = 1'b0;
            if (r < 2) begin
                cut = $urandom_range(1, 15);
            end else if (r == 2) begin
                cut = $urandom_range(1, 16);
                by_rst = 1'b1;
            end
            run_frame(rand_frame(1'b1), cut, by_rst, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 64'd0);
        check("frames_seen", frames_seen, frames_pushed);
        check("abort_count", seen_aborts, exp_aborts);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
